// File: rtl/apb_master_bridge_if.sv
// Request/response command channels plus the APB4 master-side bus of apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the command source / APB peripheral side.
`timescale 1ns/1ps
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_strb;
  logic [2:0]              cmd_prot;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB4 master bridge (IDLE/SETUP/ACCESS/RESP).
// Optional ACCESS wait-state timeout is built when APB_MASTER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb_master_bridge_if.master  bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB_WIDTH  = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    cmd_aligned;

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end
    if (LSB_WIDTH == 0) begin : g_byte_bus
      assign cmd_aligned = 1'b1;
    end else begin : g_wide_bus
      assign cmd_aligned = ~|bus.cmd_addr[LSB_WIDTH-1:0];
    end
  endgenerate

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pprot_d  = bus.cmd_prot;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
          if (cmd_aligned) begin
            state_d = S_SETUP;
          end else begin
            // Misaligned: answer locally, the APB bus never sees it.
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_ACCESS: begin
        if (bus.pready) begin
          state_d     = S_RESP;
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          // This low cycle is the TIMEOUT_CYCLES-th one: give up on the slave.
          if (wait_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
`endif
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      paddr_q     <= '0;
      pprot_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  // psel/penable decode straight from the state register so reset drops them asynchronously.
  assign bus.psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.penable   = (state_q == S_ACCESS);
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.paddr     = paddr_q;
  assign bus.pprot     = pprot_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Command-to-APB4 master bridge sitting directly upstream of the APB register slaves. Accepts single read/write commands on a valid/ready request channel, runs one APB4 transfer (SETUP then ACCESS, honouring `pready` wait states), and returns read data plus error status on a valid/ready response channel. One outstanding transfer at a time; misaligned commands are rejected locally without touching the bus.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 32: APB address width.
- `DATA_WIDTH`, default 32: APB data width, a multiple of 8. `pstrb` width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, default 16: maximum number of ACCESS cycles allowed with `pready` low. Used only with `APB_MASTER_TIMEOUT_EN`.

**Ports**

Clock and reset
- `pclk`, in, 1: single clock.
- `presetn`, in, 1: asynchronous, active-low reset.

Request channel
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: bridge can accept a command.
- `cmd_write`, in, 1: 1 = write, 0 = read.
- `cmd_addr`, in, ADDR_WIDTH: byte address.
- `cmd_wdata`, in, DATA_WIDTH: write data.
- `cmd_strb`, in, DATA_WIDTH/8: write byte strobes.
- `cmd_prot`, in, 3: protection attributes, forwarded to `pprot`.

Response channel
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_rdata`, out, DATA_WIDTH: read data; 0 for writes and for errors.
- `rsp_err`, out, 1: slave error, misalignment, or timeout.

APB master side
- `paddr`, out, ADDR_WIDTH
- `pprot`, out, 3
- `psel`, out, 1
- `penable`, out, 1
- `pwrite`, out, 1
- `pwdata`, out, DATA_WIDTH
- `pstrb`, out, DATA_WIDTH/8
- `pready`, in, 1
- `prdata`, in, DATA_WIDTH
- `pslverr`, in, 1

## Operation

The bridge is a four-state FSM: IDLE, SETUP, ACCESS, RESP.

- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`, latch all `cmd_*` fields.
  - If the address is aligned (`cmd_addr[$clog2(DATA_WIDTH/8)-1:0]` = 0), go to SETUP.
  - If the address is misaligned, go to RESP with `rsp_err` = 1 and `rsp_rdata` = 0. No APB activity occurs.
- **SETUP**
  - `psel` = 1, `penable` = 0.
  - `paddr`, `pwrite`, `pprot`, `pwdata` and `pstrb` are driven from the latched fields.
  - Reads drive `pstrb` = 0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - `psel` = 1, `penable` = 1. All APB outputs are held stable.
  - On `pready` = 1, capture `pslverr` into `rsp_err`.
  - For a read with `pslverr` = 0, capture `prdata` into `rsp_rdata`; otherwise load 0.
  - Then go to RESP.
- **RESP**
  - `rsp_valid` = 1, `psel` = `penable` = 0, `cmd_ready` = 0.
  - On `rsp_ready`, go to IDLE.
- **Outputs outside SETUP/ACCESS**
  - `psel` and `penable` are 0.
  - `paddr`, `pwrite`, `pprot`, `pwdata` and `pstrb` retain their last values.
  - `rsp_rdata` and `rsp_err` retain their values until the next response is loaded.

## Timing

- **Reset values:**
  - `cmd_ready` = 1 (IDLE).
  - All other outputs are 0: `rsp_valid`, `rsp_rdata`, `rsp_err`, `psel`, `penable`, `pwrite`, `paddr`, `pprot`, `pwdata`, `pstrb`.
- **Latency:** command accepted at edge N:
  - SETUP during cycle N..N+1.
  - ACCESS from edge N+1.
  - With zero wait states, `rsp_valid` is high from edge N+2.
  - Each `pready`-low cycle adds one cycle.
- **Throughput:** minimum 3 cycles per transfer plus 1 cycle back in IDLE, with `rsp_ready` held high.
- **Response backpressure:** `rsp_ready` low holds RESP indefinitely. No new command is accepted until the response is taken.
- **`pready` in SETUP** is ignored.
- **`pslverr`** is sampled only in ACCESS with `pready` = 1.
- **Reset mid-transfer:** `psel` and `penable` drop to 0 asynchronously, the FSM returns to IDLE, and any pending response is discarded.

## Configuration

Macro: `APB_MASTER_TIMEOUT_EN`.

- **Defined:**
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle while `pready` = 0.
  - When the counter reaches `TIMEOUT_CYCLES` with `pready` still 0, the bridge abandons the transfer: it goes to RESP with `rsp_err` = 1, `rsp_rdata` = 0, and `psel` = `penable` = 0 on the next cycle.
  - `pready` = 1 on the same cycle as the counter reaching the limit wins: the transfer completes normally.
- **Not defined:** no counter is built; ACCESS waits for `pready` forever and `TIMEOUT_CYCLES` is unused.

## Test plan

The bench connects the bridge to a register slave with BASE_ADDR=8 and N_REGS=8.

- **Write/read-back:** write 0xA5A5_0001 to 0x0C, then read 0x0C → `rsp_rdata` = 0xA5A5_0001, `rsp_err` = 0; `psel` high exactly 2 cycles; `penable` high only in the second cycle.
- **Out-of-range:** write to 0x04, then read 0x28 → `rsp_err` = 1 both times, read `rsp_rdata` = 0, one APB transfer each.
- **Misaligned:** command to 0x0E → `rsp_err` = 1, `psel` never asserted, `rsp_valid` 1 cycle after acceptance.
- **Wait states and backpressure:** stub slave with `pready` low for 3 ACCESS cycles and `rsp_ready` low for 5 cycles → APB signals stable throughout; `cmd_ready` stays 0 until the response handshake.
- **Timeout** (macro on, `TIMEOUT_CYCLES` = 4): `pready` tied low → `rsp_err` = 1 after 4 ACCESS cycles and `psel` drops. With the macro off, the bridge is still in ACCESS after 100 cycles.
- **Reset mid-ACCESS:** `presetn` low during ACCESS → `psel`/`penable` are 0 immediately, `rsp_valid` = 0, and `cmd_ready` = 1 after release.
